// File: rtl/nv_nvdla_cfgrom_walker_pkg.sv
// nv_nvdla_cfgrom_walker_pkg
// Shared types and constants for the CFGROM descriptor walker.
//   walk_state_e : walker FSM state encoding
//   desc_rec_t   : one emitted descriptor record {unit_id, offset, len}
//   CFGROM_*     : fixed CFGROM layout offsets and limits
//   desc_len_f / desc_id_f : field slices of a descriptor word
package nv_nvdla_cfgrom_walker_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_VER,
      S_RD_DESC,
      S_EMIT,
      S_RD_PAY,
      S_DONE,
      S_ERR
   } walk_state_e;

   typedef struct packed {
      logic [15:0] unit_id;
      logic [11:0] offset;
      logic [15:0] len;
   } desc_rec_t;

   localparam logic [11:0] CFGROM_LIST_BASE  = 12'h004;
   localparam logic [11:0] CFGROM_HW_VER_OFF = 12'h000;
   localparam logic [11:0] CFGROM_OFF_LIMIT  = 12'hFFC;

   // DESC word layout: [31:16] payload length in bytes, [15:0] unit id
   function automatic logic [15:0] desc_len_f(input logic [31:0] w);
      return w[31:16];
   endfunction

   function automatic logic [15:0] desc_id_f(input logic [31:0] w);
      return w[15:0];
   endfunction

endpackage

// File: rtl/nv_nvdla_cfgrom_port_arb.sv
// nv_nvdla_cfgrom_port_arb
// Shares the single combinational CFGROM read port between CSB reads and
// the walker. CSB always wins; its read data is registered and returned
// one cycle later, and holds while csb_rd_valid is low.
//   clk, rstn       : clock, synchronous active-low reset
//   csb_rd_req/offset : CSB read request
//   walk_offset     : offset the walker wants this cycle
//   rom_offset      : muxed offset to the CFGROM
//   rom_rd_data     : CFGROM data (same cycle as rom_offset)
//   walk_grant      : walker owns the port this cycle
//   csb_rd_valid/data : registered CSB response
module nv_nvdla_cfgrom_port_arb (
   input  logic        clk,
   input  logic        rstn,
   input  logic        csb_rd_req,
   input  logic [11:0] csb_rd_offset,
   input  logic [11:0] walk_offset,
   input  logic [31:0] rom_rd_data,
   output logic [11:0] rom_offset,
   output logic        walk_grant,
   output logic        csb_rd_valid,
   output logic [31:0] csb_rd_data
);

   assign rom_offset = csb_rd_req ? csb_rd_offset : walk_offset;
   assign walk_grant = ~csb_rd_req;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         csb_rd_valid <= 1'b0;
         csb_rd_data  <= 32'd0;
      end else begin
         csb_rd_valid <= csb_rd_req;
         if (csb_rd_req) csb_rd_data <= rom_rd_data;
      end
   end

endmodule

// File: rtl/nv_nvdla_cfgrom_walker.sv
// nv_nvdla_cfgrom_walker
// Walks the CFGROM descriptor list after reset or on walk_start, emitting
// one {unit_id, offset, len} record per descriptor on a valid/ready stream,
// and reports unit count, HW version and done/error status.
//   nvdla_core_clk/rstn : clock, synchronous active-low reset
//   walk_start          : start pulse (ignored while busy)
//   csb_rd_*            : CSB read access to CFGROM (priority over walker)
//   rom_offset/rd_data  : CFGROM read port
//   desc_*              : descriptor record stream
//   walk_busy/done/err  : walk status (done/err sticky until next start)
//   unit_cnt            : records accepted in current/last walk
//   hw_version          : captured HW_VERSION word
// Optional build macro NVDLA_CFGROM_WALK_CHECKSUM_EN adds payload reads and
// the walk_csum output (XOR of every word read by the walker).
module nv_nvdla_cfgrom_walker
   import nv_nvdla_cfgrom_walker_pkg::*;
#(
   parameter int          MAX_UNITS = 32,
   parameter logic [11:0] LIST_BASE = CFGROM_LIST_BASE
) (
   input  logic        nvdla_core_clk,
   input  logic        nvdla_core_rstn,
   input  logic        walk_start,
   input  logic        csb_rd_req,
   input  logic [11:0] csb_rd_offset,
   output logic        csb_rd_valid,
   output logic [31:0] csb_rd_data,
   output logic [11:0] rom_offset,
   input  logic [31:0] rom_rd_data,
   output logic        desc_valid,
   input  logic        desc_ready,
   output logic [15:0] desc_unit_id,
   output logic [11:0] desc_offset,
   output logic [15:0] desc_len,
   output logic        walk_busy,
   output logic        walk_done,
   output logic        walk_err,
   output logic [5:0]  unit_cnt,
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
   output logic [31:0] walk_csum,
`endif
   output logic [31:0] hw_version
);

   localparam logic [6:0] MAX_U = 7'(MAX_UNITS);

   walk_state_e state, state_nxt, emit_to;
   logic        start_pend;   // implicit start after reset
   logic        walk_go;
   logic        grant;
   logic        hs;
   logic        emit_err;
   logic [11:0] ptr;
   logic [11:0] walk_offset;
   logic [16:0] next_ptr;     // 17 bits so a huge len cannot wrap past 12'hFFC
   logic [6:0]  cnt_inc;
   desc_rec_t   desc_q;

`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
   logic [11:0] pay_ptr;
   logic [13:0] pay_rem;
   logic [31:0] csum;
   assign walk_csum = csum;
`endif

   nv_nvdla_cfgrom_port_arb u_arb (
      .clk           (nvdla_core_clk),
      .rstn          (nvdla_core_rstn),
      .csb_rd_req    (csb_rd_req),
      .csb_rd_offset (csb_rd_offset),
      .walk_offset   (walk_offset),
      .rom_rd_data   (rom_rd_data),
      .rom_offset    (rom_offset),
      .walk_grant    (grant),
      .csb_rd_valid  (csb_rd_valid),
      .csb_rd_data   (csb_rd_data)
   );

   assign walk_go  = walk_start | start_pend;
   assign hs       = desc_valid & desc_ready;
   assign next_ptr = {5'd0, ptr} + 17'd4 + {1'b0, desc_q.len};
   assign cnt_inc  = {1'b0, unit_cnt} + 7'd1;

`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
   assign emit_err = (next_ptr > {5'd0, CFGROM_OFF_LIMIT}) || (cnt_inc > MAX_U) ||
                     (|desc_q.len[1:0]);
   assign emit_to  = (desc_q.len != 16'd0) ? S_RD_PAY : S_RD_DESC;
`else
   assign emit_err = (next_ptr > {5'd0, CFGROM_OFF_LIMIT}) || (cnt_inc > MAX_U);
   assign emit_to  = S_RD_DESC;
`endif

   assign desc_unit_id = desc_q.unit_id;
   assign desc_offset  = desc_q.offset;
   assign desc_len     = desc_q.len;

   // state register
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) state <= S_IDLE;
      else                  state <= state_nxt;
   end

   // next state; every walking state freezes while CSB owns the port
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (walk_go) state_nxt = S_RD_VER;
         S_RD_VER:  if (grant) state_nxt = S_RD_DESC;
         S_RD_DESC: if (grant) state_nxt = (rom_rd_data == 32'd0) ? S_DONE : S_EMIT;
         S_EMIT:    if (hs) state_nxt = emit_err ? S_ERR : emit_to;
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
         S_RD_PAY:  if (grant && pay_rem == 14'd1) state_nxt = S_RD_DESC;
`endif
         S_DONE:    state_nxt = S_IDLE;
         S_ERR:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // outputs; desc_valid is masked during a CSB stall so a handshake can
   // never land on a cycle in which the walker is frozen
   always_comb begin
      walk_offset = CFGROM_HW_VER_OFF;
      desc_valid  = 1'b0;
      walk_busy   = 1'b1;
      case (state)
         S_IDLE:    walk_busy   = 1'b0;
         S_RD_DESC: walk_offset = ptr;
         S_EMIT:    desc_valid  = grant;
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
         S_RD_PAY:  walk_offset = pay_ptr;
`endif
         default: ;
      endcase
   end

   // datapath
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         start_pend <= 1'b1;
         ptr        <= 12'd0;
         desc_q     <= '0;
         unit_cnt   <= 6'd0;
         walk_done  <= 1'b0;
         walk_err   <= 1'b0;
         hw_version <= 32'd0;
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
         pay_ptr    <= 12'd0;
         pay_rem    <= 14'd0;
         csum       <= 32'd0;
`endif
      end else begin
         case (state)
            S_IDLE: if (walk_go) begin
               start_pend <= 1'b0;
               walk_done  <= 1'b0;
               walk_err   <= 1'b0;
               unit_cnt   <= 6'd0;
               ptr        <= LIST_BASE;
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
               csum       <= 32'd0;
`endif
            end
            S_RD_VER: if (grant) begin
               hw_version <= rom_rd_data;
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
               csum       <= csum ^ rom_rd_data;
`endif
            end
            S_RD_DESC: if (grant) begin
               if (rom_rd_data != 32'd0) begin
                  desc_q.unit_id <= desc_id_f(rom_rd_data);
                  desc_q.len     <= desc_len_f(rom_rd_data);
                  desc_q.offset  <= ptr;
               end
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
               csum <= csum ^ rom_rd_data;
`endif
            end
            S_EMIT: if (hs) begin
               unit_cnt <= cnt_inc[5:0];
               ptr      <= next_ptr[11:0];
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
               pay_ptr  <= ptr + 12'd4;
               pay_rem  <= desc_q.len[15:2];
`endif
            end
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
            S_RD_PAY: if (grant) begin
               csum    <= csum ^ rom_rd_data;
               pay_ptr <= pay_ptr + 12'd4;
               pay_rem <= pay_rem - 14'd1;
            end
`endif
            S_DONE: walk_done <= 1'b1;
            S_ERR:  walk_err  <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nv_nvdla_cfgrom_walker.sv
// Bench for nv_nvdla_cfgrom_walker: ROM image in an array, records collected
// by a negedge monitor and compared with a list walk computed directly from
// the image.
module tb_nv_nvdla_cfgrom_walker;

   logic        clk = 1'b0;
   logic        rstn, walk_start, csb_rd_req, desc_ready;
   logic [11:0] csb_rd_offset, rom_offset, desc_offset;
   logic        csb_rd_valid, desc_valid, walk_busy, walk_done, walk_err;
   logic [31:0] csb_rd_data, rom_rd_data, hw_version;
   logic [15:0] desc_unit_id, desc_len;
   logic [5:0]  unit_cnt;
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
   logic [31:0] walk_csum;
`endif

   logic [31:0] mem [0:1023];
   assign rom_rd_data = mem[rom_offset[11:2]];

   always #5 clk = ~clk;

   nv_nvdla_cfgrom_walker dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .walk_start      (walk_start),
      .csb_rd_req      (csb_rd_req),
      .csb_rd_offset   (csb_rd_offset),
      .csb_rd_valid    (csb_rd_valid),
      .csb_rd_data     (csb_rd_data),
      .rom_offset      (rom_offset),
      .rom_rd_data     (rom_rd_data),
      .desc_valid      (desc_valid),
      .desc_ready      (desc_ready),
      .desc_unit_id    (desc_unit_id),
      .desc_offset     (desc_offset),
      .desc_len        (desc_len),
      .walk_busy       (walk_busy),
      .walk_done       (walk_done),
      .walk_err        (walk_err),
      .unit_cnt        (unit_cnt),
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
      .walk_csum       (walk_csum),
`endif
      .hw_version      (hw_version)
   );

   int n_chk = 0, n_pass = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // monitor
   logic [43:0] got [$];
   int          busy_cyc;
   always @(negedge clk) begin
      if (rstn && desc_valid && desc_ready) got.push_back({desc_unit_id, desc_offset, desc_len});
      if (walk_busy) busy_cyc++;
   end

   // reference: walk the image straight from the list rules
   logic [43:0] exp_q [$];
   bit          exp_done, exp_err;
   int          exp_cnt, exp_cyc;

   task automatic model_walk();
      int p, nx, n, len;
      logic [31:0] w;
      exp_q.delete(); exp_done = 0; exp_err = 0; n = 0; exp_cyc = 1; p = 4;
      forever begin
         w = mem[p/4];
         exp_cyc++;
         if (w == 32'd0) begin exp_done = 1; exp_cyc++; break; end
         len = int'(w[31:16]);
         exp_q.push_back({w[15:0], 12'(p), w[31:16]});
         exp_cyc++; n++;
         nx = p + 4 + len;
         if (nx > 'hFFC || n > 32) begin exp_err = 1; exp_cyc++; break; end
`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
         exp_cyc += len / 4;
`endif
         p = nx;
      end
      exp_cnt = n;
   endtask

   task automatic cmp_walk(input string tag);
      model_walk();
      check({tag, "_nrec"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s_rec%0d", tag, i), got[i], exp_q[i]);
      check({tag, "_done"}, walk_done, exp_done);
      check({tag, "_err"}, walk_err, exp_err);
      check({tag, "_cnt"}, unit_cnt, exp_cnt);
      check({tag, "_hwver"}, hw_version, mem[0]);
   endtask

   task automatic build_std();
      int p, len;
      foreach (mem[i]) mem[i] = $urandom | 32'h1;
      mem[0] = 32'h0001_0001;
      mem[1] = {16'h0000, 16'd1};
      mem[2] = {16'h0018, 16'd2};
      mem[9] = {16'h0034, 16'd3};
      p = 'h5C;
      for (int i = 4; i <= 14; i++) begin
         len = $urandom_range(0, 16) * 4;
         mem[p/4] = {16'(len), 16'(i)};
         p += 4 + len;
      end
      mem[p/4] = 32'd0;
   endtask

   task automatic start_walk();
      got.delete(); busy_cyc = 0;
      walk_start = 1'b1;
      @(posedge clk); #1;
      walk_start = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (walk_busy && k < 3000) begin @(posedge clk); #1; k++; end
      check("walk_end", walk_busy, 0);
   endtask

   logic [43:0] hold;
   logic [11:0] po;
   logic [31:0] save;
   bit          pr;
   int          k;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rstn = 0; walk_start = 0; csb_rd_req = 0; csb_rd_offset = 0; desc_ready = 1;
      build_std();
      repeat (3) @(posedge clk); #1;
      check("rst_busy", walk_busy, 0);
      check("rst_valid", desc_valid, 0);
      check("rst_cnt", unit_cnt, 0);
      check("rst_hwver", hw_version, 0);
      check("rst_flags", {walk_done, walk_err, csb_rd_valid}, 0);
      check("rst_romoff", rom_offset, 0);

      // implicit walk after reset release
      got.delete(); busy_cyc = 0;
      rstn = 1;
      @(posedge clk); #1;
      check("auto_busy", walk_busy, 1);
      wait_idle();
      cmp_walk("std");
      check("std_cyc", busy_cyc, exp_cyc);
      check("std_cnt14", unit_cnt, 14);
      check("std_hw", hw_version, 32'h10001);
      if (got.size() >= 3) begin
         check("std_r0", got[0], {16'd1, 12'h004, 16'h0000});
         check("std_r1", got[1], {16'd2, 12'h008, 16'h0018});
         check("std_r2", got[2], {16'd3, 12'h024, 16'h0034});
      end

      // CSB burst mid-walk plus an ignored walk_start
      start_walk();
      repeat (5) @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         csb_rd_req = 1; csb_rd_offset = 12'h000;
         @(posedge clk); #1;
         check("csb_vld", csb_rd_valid, 1);
         check("csb_data", csb_rd_data, 32'h10001);
      end
      csb_rd_req = 0;
      walk_start = 1;
      @(posedge clk); #1;
      walk_start = 0;
      check("csb_vld_off", csb_rd_valid, 0);
      check("csb_hold", csb_rd_data, 32'h10001);
      wait_idle();
      cmp_walk("csb");
      check("csb_cyc", busy_cyc, exp_cyc + 5);

      // desc_ready held low on record 2
      start_walk();
      k = 0;
      while (!(desc_valid && unit_cnt == 6'd1) && k < 100) begin @(posedge clk); #1; k++; end
      check("stall_seen", desc_valid, 1);
      desc_ready = 0;
      hold = {desc_unit_id, desc_offset, desc_len};
      repeat (3) begin
         @(posedge clk); #1;
         check("stall_vld", desc_valid, 1);
         check("stall_rec", {desc_unit_id, desc_offset, desc_len}, hold);
         check("stall_cnt", unit_cnt, 1);
      end
      desc_ready = 1;
      wait_idle();
      cmp_walk("stall");
      check("stall_cyc", busy_cyc, exp_cyc + 3);

      // overflowing len on the second descriptor
      save = mem[2];
      mem[2] = {16'hFFF0, 16'd2};
      start_walk();
      wait_idle();
      cmp_walk("ovf");
      check("ovf_flags", {walk_err, walk_done}, 2'b10);
      check("ovf_cnt2", unit_cnt, 2);
      check("ovf_cyc", busy_cyc, exp_cyc);
      mem[2] = save;

      // restart after error clears flags, full sequence repeats
      start_walk();
      check("clr_flags", {walk_err, walk_done}, 0);
      check("clr_cnt", unit_cnt, 0);
      wait_idle();
      cmp_walk("rerun");

      // reset in the middle of a walk restarts it
      start_walk();
      repeat (8) @(posedge clk); #1;
      rstn = 0;
      @(posedge clk); #1;
      check("mrst_state", {walk_busy, desc_valid, unit_cnt}, 0);
      check("mrst_hw", hw_version, 0);
      got.delete(); busy_cyc = 0;
      rstn = 1;
      @(posedge clk); #1;
      wait_idle();
      cmp_walk("mrst");

      // random ready and random CSB traffic
      start_walk();
      k = 0;
      while (walk_busy && k < 2000) begin
         desc_ready = 1'($urandom_range(0, 1));
         pr = ($urandom_range(0, 3) == 0);
         po = 12'($urandom_range(0, 1023)) << 2;
         csb_rd_req = pr; csb_rd_offset = po;
         @(posedge clk); #1; k++;
         check("rnd_csb_vld", csb_rd_valid, pr);
         if (pr) check("rnd_csb_data", csb_rd_data, mem[po[11:2]]);
      end
      csb_rd_req = 0; desc_ready = 1;
      check("rnd_end", walk_busy, 0);
      cmp_walk("rnd");

`ifdef NVDLA_CFGROM_WALK_CHECKSUM_EN
      mem[0] = 32'h0001_0001;
      mem[1] = 32'h0004_0005;
      mem[2] = 32'h0000_000A;
      mem[3] = 32'h0;
      start_walk();
      wait_idle();
      check("csum", walk_csum, 32'h5000E);
      check("csum_done", walk_done, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
